// File: rtl/rr_output_arbiter_if.sv
// rtl/rr_output_arbiter_if.sv - request/grant/credit bundle between input FIFOs and one output arbiter
//
// Purpose: groups the per-output arbitration signals of one router output port.
// Signals:
//   req         [NUM_REQ]   per-input request (registered LBDR bit for this output)
//   valid       [NUM_REQ]   per-input FIFO non-empty
//   flit_id     [3*NUM_REQ] head-flit id of each input FIFO, slice i = [3i+2:3i]
//   credit_in               downstream freed one buffer slot this cycle
//   grant       [NUM_REQ]   one-hot registered grant, zero when idle
//   xbar_sel    [3]         binary index of the granted input, zero when idle
//   rd_en       [NUM_REQ]   combinational pop strobe to the granted FIFO
//   out_valid               a flit was forwarded on the previous cycle
//   credit_cnt  [3]         current downstream credit count
//   timeout_err             sticky watchdog flag
// Modports: master = router/FIFO side, slave = arbiter.

interface rr_output_arbiter_if #(
  parameter int NUM_REQ = 5
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   valid;
  logic [3*NUM_REQ-1:0] flit_id;
  logic                 credit_in;
  logic [NUM_REQ-1:0]   grant;
  logic [2:0]           xbar_sel;
  logic [NUM_REQ-1:0]   rd_en;
  logic                 out_valid;
  logic [2:0]           credit_cnt;
  logic                 timeout_err;

  modport master (
    output req, valid, flit_id, credit_in,
    input  grant, xbar_sel, rd_en, out_valid, credit_cnt, timeout_err
  );

  modport slave (
    input  req, valid, flit_id, credit_in,
    output grant, xbar_sel, rd_en, out_valid, credit_cnt, timeout_err
  );
endinterface

// File: rtl/rr_output_arbiter.sv
// rtl/rr_output_arbiter.sv - round-robin packet-locked output arbiter with credit flow control
//
// Purpose: one instance per router output port. Picks one of NUM_REQ input FIFOs
// holding a HEADER for this output, locks the grant until that input's TAIL is
// popped, and only pops while downstream credits remain.
// Ports:
//   clk  clock
//   rst  synchronous, active-high reset
//   bus  rr_output_arbiter_if.slave (req/valid/flit_id/credit_in in;
//        grant/xbar_sel/rd_en/out_valid/credit_cnt/timeout_err out)
// Optional feature: define ARB_TIMEOUT_EN to build a watchdog that force-releases
// a lock after TIMEOUT stalled cycles and raises sticky timeout_err.

`ifndef HEADER
`define HEADER  3'b001
`endif
`ifndef PAYLOAD
`define PAYLOAD 3'b010
`endif
`ifndef TAIL
`define TAIL    3'b100
`endif

module rr_output_arbiter #(
  parameter int NUM_REQ   = 5,
  parameter int BUF_DEPTH = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              rst,
  rr_output_arbiter_if.slave bus
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [2:0]           xbar_sel_q, xbar_sel_d;
  logic [2:0]           last_q, last_d;
  logic                 out_valid_q, out_valid_d;
  logic [2:0]           credit_q, credit_d;
  logic                 timeout_err_q, timeout_err_d;

  logic [NUM_REQ-1:0]   elig;
  logic                 found;
  logic [2:0]           sel;
  logic                 g_valid;
  logic [2:0]           g_flit;
  logic                 pop;
  logic                 tail_pop;
  logic                 force_rel;

  // Eligibility: only a HEADER at the head of a requesting FIFO may win.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = bus.req[i] & bus.valid[i] & (bus.flit_id[3*i +: 3] == `HEADER);
    end
  end

  // Scan last+1, last+2, ... modulo NUM_REQ; first hit wins.
  always_comb begin
    int idx;
    found = 1'b0;
    sel   = 3'd0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && elig[idx]) begin
        found = 1'b1;
        sel   = 3'(idx);
      end
    end
  end

  // Head-of-FIFO view of the locked input.
  always_comb begin
    g_valid = 1'b0;
    g_flit  = 3'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        g_valid = bus.valid[i];
        g_flit  = bus.flit_id[3*i +: 3];
      end
    end
  end

  assign pop      = (state_q == S_LOCKED) & g_valid & (credit_q != 3'd0);
  assign tail_pop = pop & (g_flit == `TAIL);

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          stalled;

  // Only idle cycles with credits count; a credit stall is downstream's fault.
  assign stalled   = (state_q == S_LOCKED) & ~pop & (credit_q != 3'd0);
  assign force_rel = stalled & (to_cnt_q == TW'(TIMEOUT - 1));

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q != S_LOCKED || pop || force_rel) begin
      to_cnt_d = '0;
    end else if (stalled) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign force_rel = 1'b0;
`endif

  // Arbitration FSM next-state and registered outputs.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    xbar_sel_d    = xbar_sel_q;
    last_d        = last_q;
    out_valid_d   = pop;
    timeout_err_d = timeout_err_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d    = S_LOCKED;
          xbar_sel_d = sel;
          for (int i = 0; i < NUM_REQ; i++) begin
            grant_d[i] = (sel == 3'(i));
          end
        end
      end
      S_LOCKED: begin
        if (tail_pop || force_rel) begin
          state_d    = S_IDLE;
          grant_d    = '0;
          xbar_sel_d = 3'd0;
          last_d     = xbar_sel_q;
        end
        if (force_rel) begin
          timeout_err_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Credit counter: a pop and a returned credit in the same cycle cancel out.
  always_comb begin
    credit_d = credit_q;
    case ({pop, bus.credit_in})
      2'b10: credit_d = credit_q - 3'd1;
      2'b01: if (credit_q != 3'(BUF_DEPTH)) credit_d = credit_q + 3'd1;
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      grant_q       <= '0;
      xbar_sel_q    <= 3'd0;
      last_q        <= 3'(NUM_REQ - 1);
      out_valid_q   <= 1'b0;
      credit_q      <= 3'(BUF_DEPTH);
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      xbar_sel_q    <= xbar_sel_d;
      last_q        <= last_d;
      out_valid_q   <= out_valid_d;
      credit_q      <= credit_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.xbar_sel    = xbar_sel_q;
  assign bus.rd_en       = grant_q & {NUM_REQ{pop}};
  assign bus.out_valid   = out_valid_q;
  assign bus.credit_cnt  = credit_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_rr_output_arbiter.sv
// tb/tb_rr_output_arbiter.sv - directed self-checking bench for rr_output_arbiter

`ifndef HEADER
`define HEADER  3'b001
`endif
`ifndef PAYLOAD
`define PAYLOAD 3'b010
`endif
`ifndef TAIL
`define TAIL    3'b100
`endif

module tb_rr_output_arbiter;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  rr_output_arbiter_if #(.NUM_REQ(5)) bif ();

  rr_output_arbiter #(.NUM_REQ(5), .BUF_DEPTH(4), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int i, input logic r, input logic v, input logic [2:0] f);
    bif.req[i]           = r;
    bif.valid[i]         = v;
    bif.flit_id[3*i +: 3] = f;
  endtask

  task automatic clr_all();
    for (int i = 0; i < 5; i++) set_port(i, 1'b0, 1'b0, `HEADER);
  endtask

  int order [6] = '{0, 1, 2, 3, 4, 0};

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bif.credit_in = 1'b0;
    bif.req = '0;
    bif.valid = '0;
    bif.flit_id = '0;
    clr_all();

    // Reset state
    tick();
    tick();
    chk("rst_grant", bif.grant, 5'b00000);
    chk("rst_xbar", bif.xbar_sel, 3'd0);
    chk("rst_oval", bif.out_valid, 1'b0);
    chk("rst_credit", bif.credit_cnt, 3'd4);
    chk("rst_terr", bif.timeout_err, 1'b0);
    rst = 1'b0;

    // Single 3-flit packet on input 1
    set_port(1, 1'b1, 1'b1, `HEADER);
    settle();
    chk("t1_idle_rd", bif.rd_en, 5'b00000);
    tick();
    chk("t1_grant", bif.grant, 5'b00010);
    chk("t1_xbar", bif.xbar_sel, 3'd1);
    chk("t1_oval0", bif.out_valid, 1'b0);
    chk("t1_rd_hdr", bif.rd_en, 5'b00010);
    tick();
    chk("t1_credit3", bif.credit_cnt, 3'd3);
    chk("t1_oval1", bif.out_valid, 1'b1);
    set_port(1, 1'b1, 1'b1, `PAYLOAD);
    settle();
    chk("t1_rd_pay", bif.rd_en, 5'b00010);
    tick();
    chk("t1_credit2", bif.credit_cnt, 3'd2);
    set_port(1, 1'b1, 1'b1, `TAIL);
    settle();
    chk("t1_rd_tail", bif.rd_en, 5'b00010);
    tick();
    chk("t1_release", bif.grant, 5'b00000);
    chk("t1_credit1", bif.credit_cnt, 3'd1);
    chk("t1_oval_tail", bif.out_valid, 1'b1);
    set_port(1, 1'b0, 1'b0, `HEADER);
    tick();
    chk("t1_oval_idle", bif.out_valid, 1'b0);
    bif.credit_in = 1'b1;
    tick();
    tick();
    tick();
    chk("t1_credit_back", bif.credit_cnt, 3'd4);
    tick();
    chk("t1_credit_sat", bif.credit_cnt, 3'd4);
    bif.credit_in = 1'b0;

    // Round robin over five 2-flit packets, credits replenished every cycle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bif.credit_in = 1'b1;
    for (int i = 0; i < 5; i++) set_port(i, 1'b1, 1'b1, `HEADER);
    settle();
    for (int n = 0; n < 6; n++) begin
      int p;
      p = order[n];
      chk("rr_bubble", bif.grant, 5'b00000);
      chk("rr_bubble_rd", bif.rd_en, 5'b00000);
      tick();
      chk("rr_grant", bif.grant, 32'(5'b00001 << p));
      chk("rr_xbar", bif.xbar_sel, 32'(p));
      chk("rr_rd_hdr", bif.rd_en, 32'(5'b00001 << p));
      tick();
      set_port(p, 1'b1, 1'b1, `TAIL);
      settle();
      chk("rr_rd_tail", bif.rd_en, 32'(5'b00001 << p));
      tick();
      set_port(p, 1'b1, 1'b1, `HEADER);
      settle();
    end
    chk("rr_credit", bif.credit_cnt, 3'd4);
    clr_all();

    // Lock hold: input 2 keeps the grant against later HEADERs
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_port(2, 1'b1, 1'b1, `HEADER);
    settle();
    tick();
    chk("lk_grant2", bif.grant, 5'b00100);
    tick();
    set_port(2, 1'b1, 1'b1, `PAYLOAD);
    set_port(0, 1'b1, 1'b1, `HEADER);
    set_port(3, 1'b1, 1'b1, `HEADER);
    set_port(4, 1'b1, 1'b1, `HEADER);
    settle();
    chk("lk_rd_pay", bif.rd_en, 5'b00100);
    tick();
    chk("lk_hold", bif.grant, 5'b00100);
    set_port(2, 1'b1, 1'b0, `PAYLOAD);
    settle();
    chk("lk_stall_rd", bif.rd_en, 5'b00000);
    tick();
    tick();
    chk("lk_hold_stall", bif.grant, 5'b00100);
    set_port(2, 1'b1, 1'b1, `TAIL);
    settle();
    chk("lk_rd_tail", bif.rd_en, 5'b00100);
    tick();
    chk("lk_release", bif.grant, 5'b00000);
    set_port(2, 1'b0, 1'b0, `HEADER);
    tick();
    chk("lk_next3", bif.grant, 5'b01000);
    tick();
    set_port(3, 1'b1, 1'b1, `TAIL);
    settle();
    tick();
    set_port(3, 1'b0, 1'b0, `HEADER);
    tick();
    chk("lk_next4", bif.grant, 5'b10000);
    tick();
    set_port(4, 1'b1, 1'b1, `TAIL);
    settle();
    tick();
    set_port(4, 1'b0, 1'b0, `HEADER);
    tick();
    chk("lk_next0", bif.grant, 5'b00001);
    tick();
    set_port(0, 1'b1, 1'b1, `TAIL);
    settle();
    tick();
    clr_all();
    bif.credit_in = 1'b0;

    // Credit stall: 6-flit packet on input 0 with BUF_DEPTH=4
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_port(0, 1'b1, 1'b1, `HEADER);
    settle();
    tick();
    chk("cr_grant", bif.grant, 5'b00001);
    tick();
    set_port(0, 1'b1, 1'b1, `PAYLOAD);
    tick();
    tick();
    tick();
    chk("cr_zero", bif.credit_cnt, 3'd0);
    chk("cr_rd_block", bif.rd_en, 5'b00000);
    chk("cr_lock_kept", bif.grant, 5'b00001);
    tick();
    chk("cr_lock_kept2", bif.grant, 5'b00001);
    chk("cr_oval_stall", bif.out_valid, 1'b0);
    bif.credit_in = 1'b1;
    settle();
    chk("cr_rd_still0", bif.rd_en, 5'b00000);
    tick();
    bif.credit_in = 1'b0;
    chk("cr_one", bif.credit_cnt, 3'd1);
    settle();
    chk("cr_rd_one", bif.rd_en, 5'b00001);
    tick();
    chk("cr_zero_again", bif.credit_cnt, 3'd0);
    chk("cr_rd_stop", bif.rd_en, 5'b00000);
    chk("cr_oval_pop", bif.out_valid, 1'b1);
    bif.credit_in = 1'b1;
    tick();
    chk("cr_one_b", bif.credit_cnt, 3'd1);
    set_port(0, 1'b1, 1'b1, `TAIL);
    settle();
    chk("cr_rd_simul", bif.rd_en, 5'b00001);
    tick();
    chk("cr_simul_const", bif.credit_cnt, 3'd1);
    chk("cr_release", bif.grant, 5'b00000);
    bif.credit_in = 1'b0;
    clr_all();

    // Reset in the middle of a 4-flit packet
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_port(1, 1'b1, 1'b1, `HEADER);
    settle();
    tick();
    tick();
    set_port(1, 1'b1, 1'b1, `PAYLOAD);
    tick();
    chk("mr_credit2", bif.credit_cnt, 3'd2);
    rst = 1'b1;
    tick();
    chk("mr_grant", bif.grant, 5'b00000);
    chk("mr_credit", bif.credit_cnt, 3'd4);
    chk("mr_oval", bif.out_valid, 1'b0);
    rst = 1'b0;
    set_port(1, 1'b0, 1'b0, `HEADER);
    set_port(4, 1'b1, 1'b1, `HEADER);
    settle();
    tick();
    chk("mr_grant4", bif.grant, 5'b10000);
    chk("mr_xbar4", bif.xbar_sel, 3'd4);

    // Watchdog: input 4's valid drops with credits available
    tick();
    set_port(4, 1'b1, 1'b0, `PAYLOAD);
    settle();
    for (int i = 0; i < 15; i++) tick();
    chk("to_hold15", bif.grant, 5'b10000);
    chk("to_terr15", bif.timeout_err, 1'b0);
    tick();
`ifdef ARB_TIMEOUT_EN
    chk("to_release", bif.grant, 5'b00000);
    chk("to_terr", bif.timeout_err, 1'b1);
    set_port(4, 1'b1, 1'b1, `HEADER);
    settle();
    tick();
    chk("to_regrant", bif.grant, 5'b10000);
    chk("to_terr_sticky", bif.timeout_err, 1'b1);
    tick();
    set_port(4, 1'b1, 1'b1, `TAIL);
    settle();
    tick();
    chk("to_tail_rel", bif.grant, 5'b00000);
    chk("to_terr_sticky2", bif.timeout_err, 1'b1);
    clr_all();
    rst = 1'b1;
    tick();
    chk("to_terr_rst", bif.timeout_err, 1'b0);
    rst = 1'b0;
`else
    chk("nto_hold16", bif.grant, 5'b10000);
    chk("nto_terr", bif.timeout_err, 1'b0);
    set_port(4, 1'b1, 1'b1, `TAIL);
    settle();
    tick();
    chk("nto_tail_rel", bif.grant, 5'b00000);
    chk("nto_terr2", bif.timeout_err, 1'b0);
    clr_all();
`endif
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
